// File: rtl/fib_disp_pkg.sv
// Shared types and constants for the Fibonacci BCD display slice.
// Holds the FSM encoding, the segment table and the nibble-adjust helper.
package fib_disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int IN_W       = 20;
   localparam int BCD_DIGITS = 7;
   localparam int BCD_W      = BCD_DIGITS * 4;
   localparam int SHIFTS     = 20;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [BCD_W-1:0] dabble_adj(
      input logic [BCD_W-1:0] w
   );
      logic [BCD_W-1:0] r;
      r = w;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (w[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one shift per clock, start/ready handshake.
// bcd holds the last finished result; the working register is never exposed.
module bin2bcd_seq #(
   parameter int IN_W = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IN_W-1:0] in_data,
   output logic            ready,
   output logic [27:0]     bcd,
   output logic            bcd_valid,
   output logic            busy
);
   import fib_disp_pkg::*;

   localparam int CNT_W = $clog2(SHIFTS + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0]  bin;
   logic [BCD_W-1:0] work;
   logic [BCD_W-1:0] adj;

   assign adj   = dabble_adj(work);
   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bin       <= '0;
         work      <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  bin   <= in_data;
                  work  <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // one extra SHIFT cycle after the last shift publishes the result
               if (cnt == CNT_W'(SHIFTS)) begin
                  bcd       <= work;
                  bcd_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  {work, bin} <= {adj, bin} << 1;
                  cnt         <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/fib_bcd_display.sv
// Fibonacci stream consumer: BCD conversion, drop counting and
// a 4-digit multiplexed 7-segment display with leading-zero blanking.
module fib_bcd_display #(
   parameter int IN_W   = 20,
   parameter int SCAN_W = 17
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [IN_W-1:0] in_data,
   output logic            in_ready,
   input  logic            page,
   output logic [27:0]     bcd,
   output logic            bcd_valid,
   output logic            busy,
   output logic [7:0]      drop_cnt,
   output logic [3:0]      an,
   output logic [6:0]      seg
);
   import fib_disp_pkg::*;

   logic [SCAN_W-1:0] scan;
   logic [1:0]        pos;
   logic [2:0]        hi;
   logic [2:0]        idx;
   logic [3:0]        digit;
   logic [31:0]       bcd_ext;

   bin2bcd_seq #(
      .IN_W(IN_W)
   ) u_conv (
      .clk      (clk),
      .rst      (rst),
      .start    (in_valid),
      .in_data  (in_data),
      .ready    (in_ready),
      .bcd      (bcd),
      .bcd_valid(bcd_valid),
      .busy     (busy)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_cnt <= '0;
         scan     <= '0;
      end else begin
         scan <= scan + 1'b1;
         if (in_valid && !in_ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign pos     = scan[SCAN_W-1 -: 2];
   assign an      = ~(4'b0001 << pos);
   assign bcd_ext = {4'h0, bcd};

   // page selects the upper bank; position 3 of page 1 maps to a digit
   // index above any possible nonzero digit, so it always blanks
   assign idx = {page, pos};

   always_comb begin
      hi = '0;
      for (int i = 1; i < BCD_DIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'h0)
            hi = 3'(i);
      end
      digit = bcd_ext[{idx, 2'b00} +: 4];
      seg   = SEG_BLANK;
      if (idx <= hi && digit <= 4'd9)
         seg = SEG_LUT[digit];
   end

endmodule

// File: tb/tb_fib_bcd_display.sv
// Self-checking bench for fib_bcd_display with a decimal-arithmetic reference.
// Runs with SCAN_W=4 so a full display scan takes 16 cycles.
module tb_fib_bcd_display;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [19:0] in_data = '0;
   logic        page = 1'b0;
   logic        in_ready;
   logic [27:0] bcd;
   logic        bcd_valid;
   logic        busy;
   logic [7:0]  drop_cnt;
   logic [3:0]  an;
   logic [6:0]  seg;

   int n_run  = 0;
   int n_fail = 0;

   logic [3:0] mscan;

   always #5 clk = ~clk;

   fib_bcd_display #(
      .IN_W  (20),
      .SCAN_W(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .page     (page),
      .bcd      (bcd),
      .bcd_valid(bcd_valid),
      .busy     (busy),
      .drop_cnt (drop_cnt),
      .an       (an),
      .seg      (seg)
   );

   // free-running refresh position as seen from outside
   always @(posedge clk) mscan <= !rst ? 4'd0 : mscan + 4'd1;

   function automatic logic [27:0] ref_bcd(input int unsigned v);
      logic [27:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 0; i < 7; i++) begin
         r[i*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] ref_glyph(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] ref_seg(
      input int unsigned v, input logic pg, input int p
   );
      int nd;
      int idx;
      int unsigned t;
      nd = 1;
      t  = v / 10;
      while (t != 0) begin
         nd++;
         t = t / 10;
      end
      if (pg && p == 3) return 7'h7F;
      idx = pg ? p + 4 : p;
      if (idx >= nd) return 7'h7F;
      t = v;
      for (int i = 0; i < idx; i++) t = t / 10;
      return ref_glyph(int'(t % 10));
   endfunction

   task automatic send_word(
      input  logic [19:0] v,
      output int          low,
      output int          pulse_at,
      output int          pulses,
      output logic [27:0] got
   );
      int w;
      low = 0; pulse_at = -1; pulses = 0; got = '0; w = 0;
      @(negedge clk);
      while (!in_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_run++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready=%b required=1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (!in_ready) low++;
         if (bcd_valid) begin
            pulses++;
            pulse_at = j;
            got = bcd;
         end
      end
   endtask

   task automatic check_scan(
      input int unsigned v, input logic pg, input string name
   );
      int p;
      logic [3:0] ea;
      logic [6:0] es;
      page = pg;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         p  = int'(mscan[3:2]);
         ea = ~(4'b0001 << p);
         es = ref_seg(v, pg, p);
         n_run++;
         if (an !== ea) begin
            n_fail++;
            $display("FAIL %s_an pos%0d: got %b required %b", name, p, an, ea);
         end
         n_run++;
         if (seg !== es) begin
            n_fail++;
            $display("FAIL %s_seg pos%0d: got %h required %h", name, p, seg, es);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; page = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      n_run++;
      if (bcd !== 28'h0) begin
         n_fail++; $display("FAIL rst_bcd: got %h required 0", bcd);
      end
      n_run++;
      if (bcd_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_bcd_valid: got %b required 0", bcd_valid);
      end
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready);
      end
      n_run++;
      if (drop_cnt !== 8'h0) begin
         n_fail++; $display("FAIL rst_drop: got %0d required 0", drop_cnt);
      end
      n_run++;
      if (an !== 4'b1110) begin
         n_fail++; $display("FAIL rst_an: got %b required 1110", an);
      end
      n_run++;
      if (seg !== 7'h40) begin
         n_fail++; $display("FAIL rst_seg: got %h required 40", seg);
      end
   endtask

   task automatic test_convert(input int unsigned v, input string name);
      int low, at, np;
      logic [27:0] got, e;
      send_word(20'(v), low, at, np, got);
      e = ref_bcd(v);
      n_run++;
      if (low !== 22) begin
         n_fail++; $display("FAIL %s_ready_low: got %0d required 22", name, low);
      end
      n_run++;
      if (np !== 1 || at !== 21) begin
         n_fail++;
         $display("FAIL %s_pulse: got %0d pulses at %0d required 1 at 21", name, np, at);
      end
      n_run++;
      if (got !== e) begin
         n_fail++; $display("FAIL %s_bcd: got %h required %h", name, got, e);
      end
   endtask

   task automatic test_small();
      test_convert(55, "v55");
      check_scan(55, 1'b0, "v55_p0");
   endtask

   task automatic test_pages();
      test_convert(831897, "v831897");
      check_scan(831897, 1'b1, "v831897_p1");
      check_scan(831897, 1'b0, "v831897_p0");
   endtask

   task automatic test_extremes();
      test_convert(1048575, "vmax");
      check_scan(1048575, 1'b1, "vmax_p1");
      test_convert(0, "vzero");
      check_scan(0, 1'b0, "vzero_p0");
   endtask

   task automatic test_random();
      int unsigned v;
      for (int k = 0; k < 4; k++) begin
         v = $urandom_range(0, 1048575);
         test_convert(v, "rand");
         check_scan(v, 1'(k & 1), "rand_scan");
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] q[$];
      logic [19:0] w, a;
      logic [27:0] e;
      logic [7:0]  ed;
      logic        er, ev;
      int          drops;
      drops = 0;
      page  = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 330; c++) begin
         // one accept every 23 edges: 22 busy cycles plus the idle one
         er = (c % 23 == 0) || (c > 321);
         ev = (c >= 22) && ((c - 22) % 23 == 0) && (c - 22 < 300);
         ed = (drops > 255) ? 8'hFF : 8'(drops);
         n_run++;
         if (in_ready !== er) begin
            n_fail++; $display("FAIL b2b_ready c%0d: got %b required %b", c, in_ready, er);
         end
         n_run++;
         if (bcd_valid !== ev) begin
            n_fail++; $display("FAIL b2b_valid c%0d: got %b required %b", c, bcd_valid, ev);
         end
         if (ev && q.size() > 0) begin
            a = q.pop_front();
            e = ref_bcd(a);
            n_run++;
            if (bcd !== e) begin
               n_fail++; $display("FAIL b2b_bcd c%0d: got %h required %h", c, bcd, e);
            end
         end
         n_run++;
         if (drop_cnt !== ed) begin
            n_fail++; $display("FAIL b2b_drop c%0d: got %0d required %0d", c, drop_cnt, ed);
         end
         w = 20'($urandom);
         in_valid = (c < 300);
         in_data  = w;
         if (c < 300) begin
            if (c % 23 == 0) q.push_back(w);
            else drops++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_run++;
      if (q.size() !== 0) begin
         n_fail++; $display("FAIL b2b_leftover: got %0d required 0", q.size());
      end
   endtask

   task automatic test_reset_abort();
      int np;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 20'd6765;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      np = 0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (bcd_valid) np++;
      end
      n_run++;
      if (np !== 0) begin
         n_fail++; $display("FAIL abort_pulse: got %0d required 0", np);
      end
      n_run++;
      if (bcd !== 28'h0) begin
         n_fail++; $display("FAIL abort_bcd: got %h required 0", bcd);
      end
      n_run++;
      if (drop_cnt !== 8'h0) begin
         n_fail++; $display("FAIL abort_drop: got %0d required 0", drop_cnt);
      end
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_ready: got %b required 1", in_ready);
      end
      test_convert(46368, "v46368");
      n_run++;
      if (bcd !== 28'h0046368) begin
         n_fail++; $display("FAIL v46368_hold: got %h required 0046368", bcd);
      end
   endtask

   initial begin
      test_reset();
      test_small();
      test_pages();
      test_extremes();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
